// File: rtl/data_mem_sized.sv
// Word-organised data memory for the MEM stage: byte/half/word access,
// sign/zero extension, alignment and range checks, fixed read latency and
// a zeroing sweep after reset.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   req_valid/ready   request handshake; ready only once the sweep is done
//   req_write         1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned      load extension: 1 = zero, 0 = sign
//   req_addr          little-endian byte address
//   req_wdata         right-justified store data
//   rsp_valid         one pulse per accepted request, READ_LAT cycles later
//   rsp_rdata         extended load data (0 for stores and errors)
//   rsp_err           misaligned, out of range or illegal size
//   init_done         level: clear sweep finished
module data_mem_sized #(
    parameter int DEPTH          = 512,
    parameter int READ_LAT       = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        init_done
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t          state;
    logic [AW-1:0]   clr_ptr;
    logic [31:0]     mem [DEPTH];

    logic            accept;
    logic            err;
    logic [AW-1:0]   idx;
    logic [31:0]     word;
    logic [7:0]      sel_byte;
    logic [15:0]     sel_half;
    logic [31:0]     ld_data;
    logic [3:0]      be;
    logic [31:0]     wd;
    logic            store_en;
    logic            clear_we;

    logic [READ_LAT-1:0] pv;
    logic [READ_LAT-1:0] pe;
    logic [31:0]         pd [READ_LAT];

    assign req_ready = (state == RUN);
    assign init_done = (state == RUN);

    // Reset wins over a request presented on the same edge.
    assign accept = req_valid && req_ready && !reset;
    assign idx    = req_addr[AW+1:2];

    assign err = (req_size == 2'b11)
               | ((req_size == 2'b01) & req_addr[0])
               | ((req_size == 2'b10) & (|req_addr[1:0]))
               | (|req_addr[31:AW+2]);

    always_comb begin
        word     = mem[idx];
        sel_byte = word[{req_addr[1:0], 3'b000} +: 8];
        sel_half = word[{req_addr[1], 4'b0000} +: 16];
        case (req_size)
            2'b00:   ld_data = {{24{~req_unsigned & sel_byte[7]}}, sel_byte};
            2'b01:   ld_data = {{16{~req_unsigned & sel_half[15]}}, sel_half};
            default: ld_data = word;
        endcase
        if (err || req_write) begin
            ld_data = '0;
        end
    end

    // Store data is replicated across lanes so byte enables alone pick
    // which bytes change.
    always_comb begin
        be = 4'b0000;
        wd = req_wdata;
        case (req_size)
            2'b00: begin
                be = 4'b0001 << req_addr[1:0];
                wd = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be = req_addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{req_wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    assign store_en = accept && req_write && !err;
    assign clear_we = (state == CLEAR) && !reset && CLEAR_ON_RESET;

    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[clr_ptr] <= '0;
        end else if (store_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wd[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (!CLEAR_ON_RESET || clr_ptr == AW'(DEPTH - 1)) begin
                        state <= RUN;
                    end
                    clr_ptr <= clr_ptr + 1'b1;
                end
                default: state <= RUN;
            endcase
        end
    end

    // Fixed-latency response shift register; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            pv <= '0;
            pe <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= accept;
            pe[0] <= accept & err;
            pd[0] <= accept ? ld_data : 32'd0;
            for (int i = 1; i < READ_LAT; i++) begin
                pv[i] <= pv[i-1];
                pe[i] <= pe[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    assign rsp_valid = pv[READ_LAT-1];
    assign rsp_err   = pe[READ_LAT-1];
    assign rsp_rdata = pd[READ_LAT-1];

endmodule
